// File: rtl/evt_cnt_pkg.sv
// Shared constants, key debounce state encoding and the seven-segment decoder
// for the event threshold counter.
package evt_cnt_pkg;

  localparam int KEY_LOAD = 0;
  localparam int KEY_CLR  = 1;
  localparam int KEY_DIR  = 2;
  localparam int NUM_KEYS = 3;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_PRESS_WAIT,
    KS_HELD,
    KS_REL_WAIT
  } key_state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/event_threshold_counter_key_edge.sv
// One push button: 2-flop synchroniser followed by a debounce FSM that emits a
// single-cycle press pulse after DEB_CYC stable pressed cycles.
module key_edge
  import evt_cnt_pkg::*;
#(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync_p0;
  logic          sync_p1;
  logic          key_down;
  key_state_e    state;
  logic [CW-1:0] stable_cnt;

  assign key_down = ~sync_p1;

  // Synchroniser flops idle at "released" so reset never looks like a press.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      state      <= KS_IDLE;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      case (state)
        KS_IDLE: begin
          stable_cnt <= '0;
          if (key_down) begin
            if (LAST == '0) begin
              state <= KS_HELD;
              press <= 1'b1;
            end else begin
              state      <= KS_PRESS_WAIT;
              stable_cnt <= ONE;
            end
          end
        end
        KS_PRESS_WAIT: begin
          if (!key_down) begin
            state      <= KS_IDLE;
            stable_cnt <= '0;
          end else if (stable_cnt == LAST) begin
            state      <= KS_HELD;
            press      <= 1'b1;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + ONE;
          end
        end
        KS_HELD: begin
          stable_cnt <= '0;
          if (!key_down) begin
            if (LAST == '0) begin
              state <= KS_IDLE;
            end else begin
              state      <= KS_REL_WAIT;
              stable_cnt <= ONE;
            end
          end
        end
        KS_REL_WAIT: begin
          if (key_down) begin
            state      <= KS_HELD;
            stable_cnt <= '0;
          end else if (stable_cnt == LAST) begin
            state      <= KS_IDLE;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + ONE;
          end
        end
        default: begin
          state      <= KS_IDLE;
          stable_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/event_threshold_counter.sv
// Debounced load/clear/direction keys drive an up/down counter of loads above
// THRESH, shown on hex displays. Define EVT_CNT_SATURATE_EN to clamp instead of wrap.
module event_threshold_counter
  import evt_cnt_pkg::*;
#(
  parameter int SW_W    = 10,
  parameter int CNT_W   = 16,
  parameter int DIGITS  = 4,
  parameter int THRESH  = 20,
  parameter int DEB_CYC = 1_000_000
) (
  input  logic                  clk100_i,
  input  logic                  rstn_i,
  input  logic [SW_W-1:0]       sw_i,
  input  logic [2:0]            key_i,
  output logic [SW_W-1:0]       ledr_o,
  output logic                  dir_o,
  output logic                  ovf_o,
  output logic [7*DIGITS-1:0]   hex_o
);

  localparam logic [31:0]      THRESH_U = 32'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] press;
  logic [SW_W-1:0]     sw_p0;
  logic [SW_W-1:0]     sw_p1;
  logic [CNT_W-1:0]    evt_cnt;
  logic                sw_over;
  logic [CNT_W:0]      step_res;

  // Returns {hit_limit, next_count}; the limit flag drives the sticky ovf.
  function automatic logic [CNT_W:0] step_count(input logic [CNT_W-1:0] cnt,
                                                input logic             down);
    logic             at_limit;
    logic [CNT_W-1:0] nxt;
    at_limit = down ? (cnt == '0) : (&cnt);
`ifdef EVT_CNT_SATURATE_EN
    if (at_limit) nxt = cnt;
    else          nxt = down ? (cnt - CNT_ONE) : (cnt + CNT_ONE);
`else
    nxt = down ? (cnt - CNT_ONE) : (cnt + CNT_ONE);
`endif
    return {at_limit, nxt};
  endfunction

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_edge #(
      .DEB_CYC (DEB_CYC)
    ) u_key (
      .clk100_i (clk100_i),
      .rstn_i   (rstn_i),
      .key_n    (key_i[k]),
      .press    (press[k])
    );
  end

  // Switch synchroniser: data path, free-running through reset.
  always_ff @(posedge clk100_i) begin
    sw_p0 <= sw_i;
    sw_p1 <= sw_p0;
  end

  assign sw_over  = (32'(sw_p1) > THRESH_U);
  assign step_res = step_count(evt_cnt, dir_o);

  // Press pulses act one cycle after they fire; the step sees the old direction.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      ledr_o  <= '0;
      evt_cnt <= '0;
      dir_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      if (press[KEY_LOAD]) ledr_o <= sw_p1;
      if (press[KEY_CLR]) begin
        evt_cnt <= '0;
        ovf_o   <= 1'b0;
      end else if (press[KEY_LOAD] && sw_over) begin
        evt_cnt <= step_res[CNT_W-1:0];
        if (step_res[CNT_W]) ovf_o <= 1'b1;
      end
      if (press[KEY_DIR]) dir_o <= ~dir_o;
    end
  end

  // Registered display decode, one cycle behind the counter.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [6:0] seg_q;
    always_ff @(posedge clk100_i) begin
      if (!rstn_i) seg_q <= hex7(4'h0);
      else         seg_q <= hex7(evt_cnt[4*d +: 4]);
    end
    assign hex_o[7*d +: 7] = seg_q;
  end

endmodule

// File: tb/tb_event_threshold_counter.sv
// Directed bench for event_threshold_counter with DEB_CYC=4 and a cycle-level
// reference model of debounce windows, latching and counting.
module tb_event_threshold_counter;

  localparam int SW_W    = 10;
  localparam int CNT_W   = 16;
  localparam int DIGITS  = 4;
  localparam int THRESH  = 20;
  localparam int DEB_CYC = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam longint HEX_0000 = 64'h8102040;

  logic                clk = 1'b0;
  logic                rstn;
  logic [SW_W-1:0]     sw;
  logic [2:0]          key;
  logic [SW_W-1:0]     ledr;
  logic                dir;
  logic                ovf;
  logic [7*DIGITS-1:0] hex;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  event_threshold_counter #(
    .SW_W    (SW_W),
    .CNT_W   (CNT_W),
    .DIGITS  (DIGITS),
    .THRESH  (THRESH),
    .DEB_CYC (DEB_CYC)
  ) dut (
    .clk100_i (clk),
    .rstn_i   (rstn),
    .sw_i     (sw),
    .key_i    (key),
    .ledr_o   (ledr),
    .dir_o    (dir),
    .ovf_o    (ovf),
    .hex_o    (hex)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  bit       m_live = 0;
  int       m_ledr, m_cnt, m_disp, m_sw1, m_sw2;
  bit       m_dir, m_ovf;
  bit [2:0] m_k1, m_k2, m_press;
  int       run_len [3];
  bit       run_dn  [3];
  bit       held    [3];

  task automatic model_step();
    bit [2:0] p_old;
    int       sw_old;
    bit       dn;
    p_old  = m_press;
    sw_old = m_sw2;
    if (!rstn) begin
      m_k1 = 3'b111; m_k2 = 3'b111; m_press = 3'b000;
      for (int k = 0; k < 3; k++) begin
        run_len[k] = 0; run_dn[k] = 0; held[k] = 0;
      end
      m_ledr = 0; m_cnt = 0; m_dir = 0; m_ovf = 0; m_disp = 0;
      m_live = 1;
    end else begin
      m_disp = m_cnt;
      if (p_old[0]) m_ledr = sw_old;
      if (p_old[1]) begin
        m_cnt = 0;
        m_ovf = 0;
      end else if (p_old[0] && sw_old > THRESH) begin
        if (!m_dir) begin
          if (m_cnt == MAXC) begin
            m_ovf = 1;
`ifdef EVT_CNT_SATURATE_EN
            m_cnt = MAXC;
`else
            m_cnt = 0;
`endif
          end else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin
            m_ovf = 1;
`ifdef EVT_CNT_SATURATE_EN
            m_cnt = 0;
`else
            m_cnt = MAXC;
`endif
          end else m_cnt = m_cnt - 1;
        end
      end
      if (p_old[2]) m_dir = !m_dir;
      // A key is accepted once its last DEB_CYC synchronised samples agree.
      for (int k = 0; k < 3; k++) begin
        dn = !m_k2[k];
        if (dn == run_dn[k]) run_len[k]++;
        else begin
          run_dn[k]  = dn;
          run_len[k] = 1;
        end
        m_press[k] = 0;
        if (!held[k] && run_dn[k] && run_len[k] >= DEB_CYC) begin
          held[k]    = 1;
          m_press[k] = 1;
        end else if (held[k] && !run_dn[k] && run_len[k] >= DEB_CYC) begin
          held[k] = 0;
        end
      end
      m_k2 = m_k1;
      m_k1 = key;
    end
    m_sw2 = m_sw1;
    m_sw1 = int'(sw);
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_live) begin
      check("ledr", ledr, m_ledr);
      check("dir", dir, m_dir);
      check("ovf", ovf, m_ovf);
      for (int d = 0; d < DIGITS; d++)
        check($sformatf("hex%0d", d), hex[7*d +: 7], seg_tab[(m_disp >> (4*d)) & 15]);
    end
  end

  task automatic press_keys(input logic [2:0] mask, input int cycles, input int swv);
    @(negedge clk);
    sw  = SW_W'(swv);
    key = ~mask;
    repeat (cycles) @(negedge clk);
    key = 3'b111;
    repeat (DEB_CYC + 6) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    sw   = '0;
    key  = 3'b111;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    check("rst_ledr", ledr, 0);
    check("rst_dir", dir, 0);
    check("rst_ovf", ovf, 0);
    check("rst_hex", hex, HEX_0000);

    // Press latency: ledr after 2+DEB_CYC+1 edges, display one edge later.
    sw  = 10'd25;
    key = 3'b110;
    repeat (6) @(posedge clk);
    #1;
    check("lat_ledr_early", ledr, 0);
    @(posedge clk);
    #1;
    check("lat_ledr", ledr, 25);
    check("lat_hex_early", hex, HEX_0000);
    @(posedge clk);
    #1;
    check("lat_hex", hex, 64'h8102079);
    @(negedge clk);
    key = 3'b111;
    repeat (DEB_CYC + 6) @(negedge clk);

    press_keys(3'b001, 8, 20);
    check("strict_ledr", ledr, 20);
    check("strict_hex", hex, 64'h8102079);

    // Bounce: 3 pressed, 1 released, 6 pressed.
    @(negedge clk);
    sw  = 10'd22;
    key = 3'b110;
    repeat (3) @(negedge clk);
    key = 3'b111;
    @(negedge clk);
    key = 3'b110;
    repeat (6) @(negedge clk);
    key = 3'b111;
    repeat (DEB_CYC + 6) @(negedge clk);
    check("bounce_hex", hex, 64'h8102024);

    press_keys(3'b001, 100, 23);
    check("hold_hex", hex, 64'h8102030);

    press_keys(3'b010, 8, 0);
    check("clr_hex", hex, HEX_0000);
    press_keys(3'b100, 8, 0);
    check("tog_dir", dir, 1);
    press_keys(3'b001, 8, 30);
    check("down_ovf", ovf, 1);
`ifdef EVT_CNT_SATURATE_EN
    check("down_sat_hex", hex, HEX_0000);
`else
    check("down_wrap_hex", hex, 64'h1C3870E);
`endif
    press_keys(3'b001, 8, 30);
    press_keys(3'b100, 8, 0);
    check("tog_back", dir, 0);
    press_keys(3'b001, 8, 30);
`ifdef EVT_CNT_SATURATE_EN
    check("up1_hex", hex, 64'h8102079);
`else
    check("up1_hex", hex, 64'h1C3870E);
`endif
    press_keys(3'b001, 8, 30);
    check("up2_ovf", ovf, 1);
`ifdef EVT_CNT_SATURATE_EN
    check("up2_hex", hex, 64'h8102024);
`else
    check("up2_hex", hex, HEX_0000);
`endif

    press_keys(3'b001, 8, 25);
    press_keys(3'b011, 8, 40);
    check("clrload_hex", hex, HEX_0000);
    check("clrload_ovf", ovf, 0);
    check("clrload_ledr", ledr, 40);

    // Reset during PRESS_WAIT discards the partial press.
    press_keys(3'b100, 8, 0);
    @(negedge clk);
    sw  = 10'd50;
    key = 3'b110;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    key = 3'b111;
    repeat (20) @(negedge clk);
    check("midrst_ledr", ledr, 0);
    check("midrst_dir", dir, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_hex", hex, HEX_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
